// File: rtl/calc_pkg.sv
// Shared keypad types, key-code constants and small scan helpers.
package calc_pkg;

  localparam int unsigned ROW_W     = 4;
  localparam int unsigned COL_W     = 4;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned DEB_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] row_idx;
    logic [IDX_W-1:0] col_idx;
  } key_code_t;

  localparam logic [3:0] KEY_PLUS = 4'hc;
  localparam logic [3:0] KEY_1    = 4'hf;
  localparam logic [3:0] KEY_2    = 4'hd;
  localparam logic [3:0] KEY_3    = 4'he;

  // Index of the lowest-numbered active-low row line.
  function automatic logic [IDX_W-1:0] lowest_low(input logic [ROW_W-1:0] r);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(ROW_W) - 1; i >= 0; i--) begin
      if (!r[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [COL_W-1:0] col_drive(input logic [IDX_W-1:0] idx);
    return ~(COL_W'(1) << idx);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every T1ms clocks, shared with the display scanner.
module tick_gen #(
  parameter int unsigned T1ms = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = (T1ms > 1) ? $clog2(T1ms) : 1;

  logic [CNT_W-1:0] cnt;

  // tick is registered so it is high exactly while cnt == T1ms-1
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CNT_W'(T1ms - 2));
      if (cnt == CNT_W'(T1ms - 1)) cnt <= '0;
      else                         cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with press/release debounce and one-shot key reporting.
module keypad_scan
  import calc_pkg::*;
#(
  parameter int unsigned T1ms  = 100000,
  parameter int unsigned DEB_N = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  logic                 tick;
  logic [ROW_W-1:0]     row_m, row_s;
  state_t               state, state_nx;
  logic [IDX_W-1:0]     col_idx, col_idx_nx;
  logic [IDX_W-1:0]     row_idx, row_idx_nx;
  logic [DEB_CNT_W-1:0] deb_cnt, deb_cnt_nx, deb_inc;
  key_code_t            code_r, code_nx;
  logic                 valid_nx, held_nx;

  tick_gen #(.T1ms(T1ms)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign key_code = code_r;

  // Row synchroniser and all FSM/output registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      row_m     <= 4'hf;
      row_s     <= 4'hf;
      state     <= ST_SCAN;
      col_idx   <= '0;
      row_idx   <= '0;
      deb_cnt   <= '0;
      code_r    <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      col       <= 4'b1110;
    end else begin
      row_m     <= row;
      row_s     <= row_m;
      state     <= state_nx;
      col_idx   <= col_idx_nx;
      row_idx   <= row_idx_nx;
      deb_cnt   <= deb_cnt_nx;
      code_r    <= code_nx;
      key_valid <= valid_nx;
      key_held  <= held_nx;
      col       <= col_drive(col_idx_nx);
    end
  end

  // Next-state logic; every decision is taken only on a scan tick
  always_comb begin
    state_nx   = state;
    col_idx_nx = col_idx;
    row_idx_nx = row_idx;
    deb_cnt_nx = deb_cnt;
    code_nx    = code_r;
    valid_nx   = 1'b0;
    held_nx    = key_held;
    deb_inc    = deb_cnt + DEB_CNT_W'(1);

    if (tick) begin
      unique case (state)
        ST_SCAN: begin
          if (row_s == 4'hf) begin
            col_idx_nx = col_idx + IDX_W'(1);
          end else begin
            row_idx_nx = lowest_low(row_s);
            deb_cnt_nx = '0;
            if (DEB_N == 1) begin
              code_nx  = {row_idx_nx, col_idx};
              valid_nx = 1'b1;
              held_nx  = 1'b1;
              state_nx = ST_HOLD;
            end else begin
              state_nx = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!row_s[row_idx]) begin
            if (deb_inc == DEB_CNT_W'(DEB_N - 1)) begin
              deb_cnt_nx = '0;
              code_nx    = {row_idx, col_idx};
              valid_nx   = 1'b1;
              held_nx    = 1'b1;
              state_nx   = ST_HOLD;
            end else begin
              deb_cnt_nx = deb_inc;
            end
          end else begin
            state_nx   = ST_SCAN;
            col_idx_nx = col_idx + IDX_W'(1);
          end
        end
        ST_HOLD: begin
          // Release needs DEB_N consecutive all-high ticks; any low line restarts the run
          if (row_s == 4'hf) begin
            if (deb_inc == DEB_CNT_W'(DEB_N)) begin
              deb_cnt_nx = '0;
              held_nx    = 1'b0;
              state_nx   = ST_SCAN;
              col_idx_nx = col_idx + IDX_W'(1);
            end else begin
              deb_cnt_nx = deb_inc;
            end
          end else begin
            deb_cnt_nx = '0;
          end
        end
        default: state_nx = ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed keypad scenarios checked every cycle against a tick-level behavioural model.
`timescale 1ns/1ps
module tb_keypad_scan;
  import calc_pkg::*;

  localparam int T  = 4;
  localparam int DN = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_held;
  logic [15:0] pressed = '0;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  keypad_scan #(.T1ms(T), .DEB_N(DN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key (r,c) pulls row r low while column c is driven low
  always_comb begin
    row = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state: consecutive-sample runs rather than a state encoding
  int         pc, mcol, watch_row, low_run, high_run;
  bit         holding;
  logic [3:0] msm, mss, row_in, exp_col, exp_code;
  logic       exp_valid, exp_held;

  task automatic model_confirm();
    holding   = 1'b1;
    high_run  = 0;
    exp_valid = 1'b1;
    exp_held  = 1'b1;
    exp_code  = 4'(watch_row * 4 + mcol);
  endtask

  always begin
    @(posedge clk);
    row_in = row;
    if (rst_n) begin
      pc = 0; msm = 4'hf; mss = 4'hf; mcol = 0; watch_row = -1;
      holding = 1'b0; low_run = 0; high_run = 0;
      exp_valid = 1'b0; exp_held = 1'b0; exp_code = 4'h0;
    end else begin
      exp_valid = 1'b0;
      if (pc == T - 1) begin
        if (holding) begin
          if (mss == 4'hf) begin
            high_run++;
            if (high_run == DN) begin
              holding = 1'b0; exp_held = 1'b0; watch_row = -1;
              mcol = (mcol + 1) % 4;
            end
          end else begin
            high_run = 0;
          end
        end else if (watch_row < 0) begin
          if (mss == 4'hf) mcol = (mcol + 1) % 4;
          else begin
            for (int i = 3; i >= 0; i--) if (!mss[i]) watch_row = i;
            low_run = 1;
            if (low_run == DN) model_confirm();
          end
        end else if (!mss[watch_row]) begin
          low_run++;
          if (low_run == DN) model_confirm();
        end else begin
          watch_row = -1;
          mcol = (mcol + 1) % 4;
        end
      end
      pc  = (pc + 1) % T;
      mss = msm;
      msm = row_in;
    end
    exp_col = ~(4'b0001 << mcol);
    #1;
    if (key_valid === 1'b1) vcount++;
    check("col", 32'(col), 32'(exp_col));
    check("key_valid", 32'(key_valid), 32'(exp_valid));
    check("key_held", 32'(key_held), 32'(exp_held));
    check("key_code", 32'(key_code), 32'(exp_code));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_held(input logic val, input int bound, input string name, output int k);
    k = 0;
    while (key_held !== val && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(key_held), 32'(val));
  endtask

  task automatic wait_col(input logic [3:0] val, input int bound, input string name);
    int k;
    k = 0;
    while (col !== val && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(col), 32'(val));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] seq [5];
    logic [3:0] prev;
    int         k;
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111; seq[4] = 4'b1110;

    // Reset values
    cyc(3);
    check("rst_col", 32'(col), 32'h0000000e);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held", 32'(key_held), 32'h0);
    check("rst_code", 32'(key_code), 32'h0);
    rst_n = 1'b0;
    cyc(1);
    check("col_after_rst", 32'(col), 32'h0000000e);

    // Idle scanning: column walks 1110,1101,1011,0111,1110
    for (int i = 1; i < 5; i++) begin
      prev = col;
      k = 0;
      while (col === prev && k < 8) begin
        @(negedge clk);
        k++;
      end
      check("idle_seq", 32'(col), 32'(seq[i]));
    end
    cyc(12 * T);
    check("idle_no_valid", 32'(vcount), 32'h0);

    // Key (3,3) held for 40 ticks
    pressed[15] = 1'b1;
    wait_held(1'b1, 200, "k33_held", k);
    check("k33_code", 32'(key_code), 32'(KEY_1));
    cyc(36 * T);
    check("k33_one_pulse", 32'(vcount), 32'h1);
    check("k33_col_frozen", 32'(col), 32'h00000007);
    check("k33_still_held", 32'(key_held), 32'h1);

    // Release: held drops on the third all-high tick seen through the synchroniser
    pressed = '0;
    wait_held(1'b0, 40, "k33_release", k);
    check("k33_rel_lat", 32'(k >= 11 && k <= 14), 32'h1);
    check("rescan_col0", 32'(col), 32'h0000000e);

    // One-tick bounce on (3,0)
    pressed[12] = 1'b1;
    cyc(T);
    pressed = '0;
    cyc(T);
    check("bounce_rescan", 32'(col), 32'h0000000d);
    cyc(20);
    check("bounce_no_valid", 32'(vcount), 32'h1);
    check("bounce_not_held", 32'(key_held), 32'h0);

    // (3,1) then (3,2) added during HOLD
    pressed[13] = 1'b1;
    wait_held(1'b1, 200, "k31_held", k);
    check("k31_code", 32'(key_code), 32'(KEY_2));
    pressed[14] = 1'b1;
    cyc(40);
    check("k31_single_pulse", 32'(vcount), 32'h2);
    check("k31_col_frozen", 32'(col), 32'h0000000d);
    pressed = '0;
    wait_held(1'b0, 40, "k31_release", k);
    cyc(8);
    check("k32_no_early_pulse", 32'(vcount), 32'h2);
    pressed[14] = 1'b1;
    wait_held(1'b1, 200, "k32_held", k);
    check("k32_code", 32'(key_code), 32'(KEY_3));
    check("k32_pulse", 32'(vcount), 32'h3);

    // Reset in the middle of debouncing (3,2)
    pressed = '0;
    wait_held(1'b0, 40, "k32_release", k);
    pressed[14] = 1'b1;
    wait_col(4'b1011, 100, "k32_col_reach");
    cyc(6);
    rst_n = 1'b1;
    pressed = '0;
    cyc(1);
    check("midrst_valid", 32'(key_valid), 32'h0);
    check("midrst_col", 32'(col), 32'h0000000e);
    cyc(2);
    rst_n = 1'b0;
    cyc(1);
    check("col_after_rst2", 32'(col), 32'h0000000e);
    cyc(20);
    check("midrst_no_pulse", 32'(vcount), 32'h3);
    check("midrst_not_held", 32'(key_held), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter T1ms, default 100000: clock cycles per scan tick; legal range >= 4.
REQ-002 Parameter DEB_N, default 10: number of consecutive ticks that confirm a press or a release; legal range 1..15.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  one clock; reset is synchronous and active-high (rst_n = 1 resets).
REQ-005 row  input  4  keypad row sense lines, active-low, asynchronous to clk.
REQ-006 col  output  4  keypad column drive, one-hot active-low.
REQ-007 key_valid  output  1  single-cycle pulse when a debounced press is confirmed.
REQ-008 key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the last confirmed key; stable between pulses.
REQ-009 key_held  output  1  high from the key_valid cycle until the release is confirmed.

Function
REQ-010 Synchronise row through a 2-flop stage; all decisions use only the synchronised value row_s.
REQ-011 Prescaler counts 0..T1ms-1 and asserts tick for one cycle at T1ms-1, then wraps to 0.
REQ-012 col_idx drives col = ~(4'b0001 << col_idx); col changes only in the cycle after a tick.
REQ-013 State machine has three states: SCAN, DEBOUNCE, HOLD.
REQ-014 SCAN, on tick with row_s == 4'b1111: col_idx increments mod 4 (3 wraps to 0).
REQ-015 SCAN, on tick with row_s != 4'b1111:
- latch row_idx = index of the lowest-numbered low bit;
- clear deb_cnt;
- go to DEBOUNCE; col_idx is held.
REQ-016 DEBOUNCE, on tick with row_s[row_idx] == 0: deb_cnt increments.
REQ-017 DEBOUNCE, when deb_cnt reaches DEB_N-1 at a tick:
- key_code is loaded;
- key_valid pulses in the next cycle;
- go to HOLD.
REQ-018 DEBOUNCE, on tick with row_s[row_idx] == 1: return to SCAN with no pulse; col_idx advances.
REQ-019 HOLD:
- col_idx is held;
- deb_cnt counts ticks with row_s == 4'b1111 and clears on any tick with a low bit.
REQ-020 HOLD, at DEB_N consecutive release ticks: clear key_held, go to SCAN, col_idx advances.
REQ-021 Other keys pressed during DEBOUNCE or HOLD are ignored; no second pulse occurs until release is confirmed.
REQ-022 Exactly one key_valid pulse per confirmed press; key_valid is never high for two consecutive cycles.
REQ-023 Latency: key_valid rises no later than (DEB_N+1) ticks plus 4 cycles after the key's column is driven.
REQ-024 When DEB_N = 1, a single low sample confirms the press: the SCAN detection tick goes directly to the pulse and to HOLD.

Reset
REQ-025 While rst_n is high, each register takes its reset value:
- state = SCAN;
- col_idx = 0, so col = 4'b1110;
- prescaler = 0 and deb_cnt = 0;
- key_valid = 0, key_held = 0, key_code = 4'h0;
- both synchroniser flops = 4'b1111.
REQ-026 Reset in any state, including mid-debounce or HOLD, aborts the operation with no key_valid pulse; scanning restarts from column 0 in the first cycle after rst_n falls.

Structure
REQ-027 State encodings and the key-code constants belong in the shared package calc_pkg:
- KEY_PLUS = 4'hc;
- the digit codes KEY_1 = 4'hf, KEY_2 = 4'hd, KEY_3 = 4'he.
REQ-028 The prescaler is a separate sub-module tick_gen (parameter T1ms; output tick) so the display scanner can reuse it.

Verification
REQ-029 The bench uses T1ms = 4, DEB_N = 3, and a keypad model with row[r] = col[c] for the pressed key (r, c).
REQ-030 Reset, then no key held for 16 ticks -> col cycles 1110, 1101, 1011, 0111, 1110 on each tick; key_valid stays 0.
REQ-031 Hold key (3, 3) for 40 ticks -> exactly one key_valid with key_code = 4'hf, key_held = 1; col frozen at 0111.
REQ-032 Release that key -> key_held falls after 3 release ticks; scanning resumes at col = 1110.
REQ-033 Press (3, 0) for 1 tick only (bounce) -> no key_valid; back in SCAN.
REQ-034 Press (3, 1), then add (3, 2) while in HOLD -> a single pulse with key_code = 4'hd; no pulse for 4'he until both are released and (3, 2) is pressed alone.
REQ-035 Assert rst_n during DEBOUNCE of (3, 2) -> no pulse; col = 1110 one cycle after reset is released.
